// File: rtl/gray_level_inverse.sv
// Inverse gray-level transform: restoring divide of (gray x gain) by gain, one
// quotient bit per cycle, then round half-up and saturate to an OUT_W gray level.
module gray_level_inverse #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int GAIN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [GAIN_W-1:0] in_gain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              out_div0
);

  localparam int CNT_W = $clog2(IN_W);
  localparam logic [OUT_W-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {IDLE, DIV, FIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   dividend_q, dividend_d;
  logic [GAIN_W-1:0] divisor_q, divisor_d;
  logic [GAIN_W:0]   rem_q, rem_d;
  logic [IN_W-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div0_q, div0_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic              out_div0_q, out_div0_d;

  logic [GAIN_W:0]   rem_shift;
  logic [IN_W:0]     qr;

  // Widened by one bit so q = 2^IN_W-1 plus a round-up increment cannot wrap.
  function automatic logic [IN_W:0] round_half_up(input logic [IN_W-1:0]   q,
                                                  input logic [GAIN_W:0]   rem,
                                                  input logic [GAIN_W-1:0] div);
    logic [GAIN_W+1:0] rem2;
    logic [IN_W:0]     inc;
    rem2   = {rem, 1'b0};
    inc    = '0;
    inc[0] = (rem2 >= {2'b00, div});
    return {1'b0, q} + inc;
  endfunction

  function automatic logic exceeds_out_range(input logic [IN_W:0] v);
    return |v[IN_W:OUT_W];
  endfunction

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    div0_d     = div0_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    out_div0_d = out_div0_q;
    rem_shift  = {rem_q[GAIN_W-1:0], dividend_q[cnt_q]};
    qr         = round_half_up(quot_q, rem_q, divisor_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dividend_d = in_data;
          divisor_d  = in_gain;
          rem_d      = '0;
          quot_d     = '0;
          cnt_d      = CNT_W'(IN_W - 1);
          div0_d     = (in_gain == '0);
          state_d    = (in_gain == '0) ? FIN : DIV;
        end
      end
      // ---- divide: one restoring step per cycle, MSB first ----
      DIV: begin
        if (rem_shift >= {1'b0, divisor_q}) begin
          rem_d         = rem_shift - {1'b0, divisor_q};
          quot_d[cnt_q] = 1'b1;
        end else begin
          rem_d         = rem_shift;
          quot_d[cnt_q] = 1'b0;
        end
        if (cnt_q == '0) state_d = FIN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      // ---- finish: round, saturate, register result ----
      FIN: begin
        if (div0_q || exceeds_out_range(qr)) begin
          out_data_d = SAT_MAX;
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = qr[OUT_W-1:0];
          out_sat_d  = 1'b0;
        end
        out_div0_d = div0_q;
        state_d    = DONE;
      end
      // ---- hold result until downstream takes it ----
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      div0_q     <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      out_div0_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      div0_q     <= div0_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      out_div0_q <= out_div0_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_div0  = out_div0_q;

endmodule

// File: tb/tb_gray_level_inverse.sv
// Scoreboard bench for gray_level_inverse: directed corner cases plus random
// samples under random backpressure, checked against an arithmetic reference.
module tb_gray_level_inverse;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [7:0]  in_gain = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        out_div0;

  gray_level_inverse #(.IN_W(16), .OUT_W(8), .GAIN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_gain(in_gain),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_div0(out_div0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rnd_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       sat;
    logic       div0;
    int         rise;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: rounded quotient by plain integer arithmetic.
  function automatic exp_t model(input int d, input int g, input int acc);
    exp_t e;
    int qr;
    if (g == 0) begin
      e.data = 8'd255; e.sat = 1'b1; e.div0 = 1'b1; e.rise = acc + 1;
    end else begin
      qr = d / g + (((2 * (d % g)) >= g) ? 1 : 0);
      e.sat  = (qr > 255);
      e.data = e.sat ? 8'd255 : qr[7:0];
      e.div0 = 1'b0;
      e.rise = acc + 17;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on every output transfer.
  logic ov_prev = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) rise_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_sat", out_sat, e.sat);
          check("out_div0", out_div0, e.div0);
          check("latency", rise_cyc, e.rise);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input int d, input int g);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_gain  = 8'(g);
    @(negedge clk);
    sb.push_back(model(d, g, cyc));
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_gain  = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("drain_timeout", 0, 1);
  endtask

  int td[10] = '{400, 5, 7, 8, 511, 65535, 510, 1234, 0, 65535};
  int tg[10] = '{2,   2, 3, 3, 2,   1,     2,   0,    5, 255};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_div0", out_div0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(td[i], tg[i]);
      drain();
    end

    // Back-to-back with out_ready held high.
    send(1000, 4);
    in_gain = 8'd1;
    send(300, 7);
    send(9, 0);
    drain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(400, 2);
    begin
      int n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    check("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, 200);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    check("bp_sb_empty", sb.size(), 0);

    // Reset asserted so it lands on the eighth divide iteration.
    send(60000, 7);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    send(300, 3);
    drain();

    // Random samples with random backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int r, d, g;
      r = $urandom_range(0, 9);
      d = (r < 5) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 1023));
      if (r == 0)      g = 0;
      else if (r < 4)  g = $urandom_range(1, 3);
      else             g = $urandom_range(1, 255);
      send(d, g);
    end
    @(negedge clk);
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    check("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
